reg_mode_unit: RTL and testbench



---
 rtl/reg_mode_unit.sv | 98 +++++++++
 tb/tb_reg_mode_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reg_mode_unit.sv
// Multi-mode WIDTH-bit register (hold/load/shift/rotate/clear/increment) with
// serial chaining, a change pulse and a history of prior distinct values.
module reg_mode_unit #(
  parameter int WIDTH = 4,
  parameter int HIST_DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                                                 clk50m_i,
  input  logic                                                 rst_i,
  input  logic                                                 enable_signal_i,
  input  logic [2:0]                                           mode_i,
  input  logic [WIDTH-1:0]                                     data_i,
  input  logic                                                 serial_i,
  input  logic [((HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1)-1:0] hist_sel_i,
  output logic [WIDTH-1:0]                                     data_o,
  output logic                                                 serial_o,
  output logic                                                 changed_o,
  output logic [WIDTH-1:0]                                     hist_o,
  output logic [$clog2(HIST_DEPTH+1)-1:0]                      hist_cnt_o
);

  localparam int HCW = $clog2(HIST_DEPTH + 1);

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_SHR   = 3'd3;
  localparam logic [2:0] MODE_ROL   = 3'd4;
  localparam logic [2:0] MODE_ROR   = 3'd5;
  localparam logic [2:0] MODE_CLEAR = 3'd6;
  localparam logic [2:0] MODE_INC   = 3'd7;

  logic [WIDTH-1:0] hist_q [HIST_DEPTH];
  logic [WIDTH-1:0] data_nxt;
  logic             ser_nxt;
  logic             do_change;

  // enable_signal_i is a strobe with no back-pressure: every cycle it is high,
  // mode_i is executed on that rising edge; when low nothing moves.
  always_comb begin
    data_nxt = data_o;
    ser_nxt  = serial_o;
    case (mode_i)
      MODE_HOLD:  data_nxt = data_o;
      MODE_LOAD:  data_nxt = data_i;
      MODE_SHL: begin
        data_nxt = {data_o[WIDTH-2:0], serial_i};
        ser_nxt  = data_o[WIDTH-1];
      end
      MODE_SHR: begin
        data_nxt = {serial_i, data_o[WIDTH-1:1]};
        ser_nxt  = data_o[0];
      end
      MODE_ROL: begin
        data_nxt = {data_o[WIDTH-2:0], data_o[WIDTH-1]};
        ser_nxt  = data_o[WIDTH-1];
      end
      MODE_ROR: begin
        data_nxt = {data_o[0], data_o[WIDTH-1:1]};
        ser_nxt  = data_o[0];
      end
      MODE_CLEAR: data_nxt = RST_VAL;
      MODE_INC:   data_nxt = data_o + WIDTH'(1);
      default:    data_nxt = data_o;
    endcase
    do_change = enable_signal_i && (data_nxt != data_o);
  end

  always_ff @(posedge clk50m_i) begin
    if (rst_i) begin
      data_o     <= RST_VAL;
      serial_o   <= 1'b0;
      changed_o  <= 1'b0;
      hist_cnt_o <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      changed_o <= do_change;
      if (enable_signal_i) begin
        data_o   <= data_nxt;
        serial_o <= ser_nxt;
      end
      // Only distinct values enter the history; the oldest entry falls off.
      if (do_change) begin
        hist_q[0] <= data_o;
        for (int i = 1; i < HIST_DEPTH; i++) hist_q[i] <= hist_q[i-1];
        if (hist_cnt_o != HCW'(HIST_DEPTH)) hist_cnt_o <= hist_cnt_o + HCW'(1);
      end
    end
  end

  always_comb begin
    hist_o = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (int'(hist_sel_i) == i && int'(hist_sel_i) < int'(hist_cnt_o)) hist_o = hist_q[i];
    end
  end

endmodule

// File: tb/tb_reg_mode_unit.sv
// Directed, table-driven bench for reg_mode_unit (WIDTH=4, HIST_DEPTH=4, RST_VAL=0).
module tb_reg_mode_unit;

  localparam int W = 4;

  logic         clk50m_i;
  logic         rst_i;
  logic         enable_signal_i;
  logic [2:0]   mode_i;
  logic [W-1:0] data_i;
  logic         serial_i;
  logic [1:0]   hist_sel_i;
  logic [W-1:0] data_o;
  logic         serial_o;
  logic         changed_o;
  logic [W-1:0] hist_o;
  logic [2:0]   hist_cnt_o;

  reg_mode_unit #(.WIDTH(4), .HIST_DEPTH(4), .RST_VAL(4'h0)) dut (
    .clk50m_i(clk50m_i), .rst_i(rst_i), .enable_signal_i(enable_signal_i),
    .mode_i(mode_i), .data_i(data_i), .serial_i(serial_i), .hist_sel_i(hist_sel_i),
    .data_o(data_o), .serial_o(serial_o), .changed_o(changed_o),
    .hist_o(hist_o), .hist_cnt_o(hist_cnt_o)
  );

  // clock / reset block
  initial begin
    clk50m_i = 1'b0;
    forever #5 clk50m_i = ~clk50m_i;
  end

  typedef struct {
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] din;
    logic         sin;
    logic [1:0]   sel;
    logic [W-1:0] e_data;
    logic         e_ser;
    logic         e_chg;
    logic [2:0]   e_cnt;
    logic [W-1:0] e_hist;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad   = 0;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, CLR = 3'd6, INC = 3'd7;

  task automatic add(input logic rst, input logic en, input logic [2:0] mode,
                     input logic [W-1:0] din, input logic sin, input logic [1:0] sel,
                     input logic [W-1:0] e_data, input logic e_ser, input logic e_chg,
                     input logic [2:0] e_cnt, input logic [W-1:0] e_hist);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.din = din; v.sin = sin; v.sel = sel;
    v.e_data = e_data; v.e_ser = e_ser; v.e_chg = e_chg; v.e_cnt = e_cnt; v.e_hist = e_hist;
    vecs.push_back(v);
    exp_q.push_back(e_data);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns after the rising edge
  task automatic drive(input vec_t v);
    @(negedge clk50m_i);
    rst_i = v.rst; enable_signal_i = v.en; mode_i = v.mode;
    data_i = v.din; serial_i = v.sin; hist_sel_i = v.sel;
    @(posedge clk50m_i);
    #1;
  endtask

  initial begin
    logic [W-1:0] exp_d;
    rst_i = 1'b1; enable_signal_i = 1'b0; mode_i = HOLD;
    data_i = '0; serial_i = 1'b0; hist_sel_i = '0;

    //  rst en mode din sin sel | data ser chg cnt hist
    add(1, 0, HOLD, 4'h0, 0, 0,   4'h0, 0, 0, 0, 4'h0);
    add(1, 0, HOLD, 4'h0, 0, 0,   4'h0, 0, 0, 0, 4'h0);
    add(0, 1, HOLD, 4'h0, 0, 0,   4'h0, 0, 0, 0, 4'h0);
    add(0, 1, HOLD, 4'h0, 0, 0,   4'h0, 0, 0, 0, 4'h0);
    add(0, 1, HOLD, 4'h0, 0, 0,   4'h0, 0, 0, 0, 4'h0);
    add(0, 1, LOAD, 4'hA, 0, 0,   4'hA, 0, 1, 1, 4'h0);
    add(0, 0, LOAD, 4'h5, 0, 0,   4'hA, 0, 0, 1, 4'h0);
    add(0, 1, LOAD, 4'h9, 0, 0,   4'h9, 0, 1, 2, 4'hA);
    add(0, 1, SHL,  4'h0, 0, 0,   4'h2, 1, 1, 3, 4'h9);
    add(0, 1, SHR,  4'h0, 1, 1,   4'h9, 0, 1, 4, 4'h9);
    add(0, 1, ROR,  4'h0, 0, 3,   4'hC, 1, 1, 4, 4'hA);
    add(0, 1, ROL,  4'h0, 0, 0,   4'h9, 1, 1, 4, 4'hC);
    add(0, 1, LOAD, 4'hE, 0, 2,   4'hE, 1, 1, 4, 4'h9);
    add(0, 1, INC,  4'h0, 0, 0,   4'hF, 1, 1, 4, 4'hE);
    add(0, 1, INC,  4'h0, 0, 0,   4'h0, 1, 1, 4, 4'hF);
    add(0, 0, INC,  4'h0, 0, 1,   4'h0, 1, 0, 4, 4'hE);
    add(0, 1, ROL,  4'h0, 0, 0,   4'h0, 0, 0, 4, 4'hF);
    add(0, 1, CLR,  4'h0, 0, 0,   4'h0, 0, 0, 4, 4'hF);
    // history saturation from reset
    add(1, 1, LOAD, 4'h7, 0, 0,   4'h0, 0, 0, 0, 4'h0);
    add(0, 1, LOAD, 4'h1, 0, 0,   4'h1, 0, 1, 1, 4'h0);
    add(0, 1, LOAD, 4'h2, 0, 0,   4'h2, 0, 1, 2, 4'h1);
    add(0, 1, LOAD, 4'h3, 0, 1,   4'h3, 0, 1, 3, 4'h1);
    add(0, 1, LOAD, 4'h4, 0, 3,   4'h4, 0, 1, 4, 4'h0);
    add(0, 1, LOAD, 4'h5, 0, 3,   4'h5, 0, 1, 4, 4'h1);
    add(0, 1, LOAD, 4'h6, 0, 0,   4'h6, 0, 1, 4, 4'h5);
    add(0, 1, LOAD, 4'h6, 0, 3,   4'h6, 0, 0, 4, 4'h2);
    add(0, 0, HOLD, 4'h0, 0, 1,   4'h6, 0, 0, 4, 4'h4);
    add(0, 0, HOLD, 4'h0, 0, 2,   4'h6, 0, 0, 4, 4'h3);
    // reset in the middle of an INC run
    add(0, 1, INC,  4'h0, 0, 0,   4'h7, 0, 1, 4, 4'h6);
    add(0, 1, INC,  4'h0, 0, 0,   4'h8, 0, 1, 4, 4'h7);
    add(0, 1, SHL,  4'h0, 1, 0,   4'h1, 1, 1, 4, 4'h8);
    add(0, 1, INC,  4'h0, 0, 0,   4'h2, 1, 1, 4, 4'h1);
    add(1, 1, INC,  4'h0, 0, 0,   4'h0, 0, 0, 0, 4'h0);
    add(0, 1, INC,  4'h0, 0, 0,   4'h1, 0, 1, 1, 4'h0);
    add(0, 1, INC,  4'h0, 0, 0,   4'h2, 0, 1, 2, 4'h1);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      exp_d = exp_q.pop_front();
      check("data_o",     i, 32'(data_o),     32'(exp_d));
      check("serial_o",   i, 32'(serial_o),   32'(vecs[i].e_ser));
      check("changed_o",  i, 32'(changed_o),  32'(vecs[i].e_chg));
      check("hist_cnt_o", i, 32'(hist_cnt_o), 32'(vecs[i].e_cnt));
      check("hist_o",     i, 32'(hist_o),     32'(vecs[i].e_hist));
    end

    // no combinational path: a LOAD set up mid-cycle must not show before the edge
    @(negedge clk50m_i);
    rst_i = 1'b0; enable_signal_i = 1'b1; mode_i = LOAD; data_i = 4'hD; hist_sel_i = 2'd1;
    #2;
    check("no_comb_path", 100, 32'(data_o), 32'h2);
    @(posedge clk50m_i);
    #1;
    check("load_after_edge", 101, 32'(data_o), 32'hD);
    check("pulse_high", 101, 32'(changed_o), 32'h1);
    check("hist_sel1_after_load", 101, 32'(hist_o), 32'h1);
    // pulse drops after one cycle once the strobe is removed
    @(negedge clk50m_i);
    enable_signal_i = 1'b0; data_i = 4'h3;
    @(posedge clk50m_i);
    #1;
    check("pulse_low", 102, 32'(changed_o), 32'h0);
    check("hold_when_disabled", 102, 32'(data_o), 32'hD);
    check("cnt_after_disabled", 102, 32'(hist_cnt_o), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
